mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum number of cycles the FSM waits for Mem_Ack before it enters ERR.
REQ-002 Clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Opcode  in  6  IR[31:26]; also drives the immediate extender directly.
REQ-005 Func  in  6  IR[5:0]; R-type ALU function, low 4 bits used.
REQ-006 Zero  in  1  ALU zero flag, valid in BR.
REQ-007 Mem_Ack  in  1  memory completion strobe for the current Mem_Req.
REQ-008 PC_sel  out  1  0 = PC+4, 1 = PC+4+ext_imm.
REQ-009 PC_LdEn, IR_LdEn, MDR_LdEn, RF_WrEn  out  1 each  register load strobes.
REQ-010 RF_B_sel  out  1  0 = rt, 1 = rd as the second read address.
REQ-011 RF_WrData_sel  out  1  0 = ALU result, 1 = MDR.
REQ-012 ALU_Bin_sel  out  1  0 = RF B, 1 = extended immediate.
REQ-013 ALU_func  out  4  ALU operation code: 0000 add, 0001 sub, 0010 and, 0011 or.
REQ-014 Mem_Req, Mem_WrEn, Mem_InstrSel, ByteOp  out  1 each  memory request, write, instruction-port select, and byte access.
REQ-015 Err  out  1  sticky fault flag.

Function
REQ-016 Opcodes are: R 100000; li 111000; lui 111001; addi 110000; andi 110010; ori 110011; b 111111; beq 000000; bne 000001; lb 000011; lw 001111; sb 000111; sw 011111. Any other opcode is illegal.
REQ-017 States are IDLE, IF, DEC, EXR, EXI, BR, ADR, MRD, MWR, WB, ERR.
REQ-018 Outputs are Moore-decoded from state, except IR_LdEn, MDR_LdEn and the MWR-exit PC_LdEn, which are qualified with Mem_Ack; every output not asserted in the current state is 0.
REQ-019 IDLE: all outputs 0; go to IF next cycle.
REQ-020 IF: Mem_Req=1, Mem_InstrSel=1; on Mem_Ack assert IR_LdEn and go to DEC.
REQ-021 DEC: one cycle; next state is R->EXR; li/lui/addi/andi/ori->EXI; b/beq/bne->BR; lb/lw/sb/sw->ADR; illegal->ERR.
REQ-022 EXR: ALU_Bin_sel=0, ALU_func=Func[3:0]; go to WB.
REQ-023 EXI: ALU_Bin_sel=1; ALU_func=0010 for andi, 0011 for ori, 0000 otherwise; go to WB.
REQ-024 BR: RF_B_sel=1, ALU_func=0001, PC_LdEn=1; PC_sel=1 for b, for beq when Zero=1, and for bne when Zero=0, else 0; go to IF.
REQ-025 ADR: ALU_Bin_sel=1, ALU_func=0000; lb/lw go to MRD; sb/sw go to MWR (with RF_B_sel=1).
REQ-026 MRD: Mem_Req=1, ByteOp=1 for lb; on Mem_Ack assert MDR_LdEn and go to WB.
REQ-027 MWR: Mem_Req=1, Mem_WrEn=1, RF_B_sel=1, ByteOp=1 for sb; on Mem_Ack assert PC_LdEn with PC_sel=0 and go to IF.
REQ-028 WB: RF_WrEn=1; RF_WrData_sel=1 only after MRD; PC_LdEn=1, PC_sel=0; go to IF.
REQ-029 Latency with zero-wait memory: branch 3 cycles; R, I-type and store 4 cycles; load 5 cycles.
REQ-030 Wait counter:
  - clears on entry to IF, MRD or MWR;
  - increments on each cycle without Mem_Ack;
  - if it reaches MEM_WAIT_MAX without Mem_Ack, go to ERR with Mem_Req dropped.
REQ-031 Mem_Ack in any state other than IF, MRD or MWR is ignored; Mem_Ack arriving in the same cycle the counter reaches MEM_WAIT_MAX takes priority over the timeout.
REQ-032 ERR: Err=1, all other outputs 0; remain there until Reset.
REQ-033 Opcode and Func are sampled only in DEC, EXR, EXI, BR, ADR, MRD, MWR and WB; they are ignored in IF.

Reset
REQ-034 Reset forces state to IDLE, clears the counter, and drives all outputs to 0 asynchronously, including mid-transaction (Mem_Req falls immediately).
REQ-035 After Reset deasserts, the first Mem_Req rises one cycle later, in IF.

Structure
REQ-036 Opcode constants, ALU_func codes and state encoding live in the shared package mc_defs.
REQ-037 The wait counter and timeout compare are one sub-module, mc_wait_timer, with inputs clear and enable and output expired.

Verification
REQ-038 addi, Mem_Ack held at 1 -> IF, DEC, EXI, WB; ALU_Bin_sel=1, ALU_func=0000; RF_WrEn and PC_LdEn in cycle 4.
REQ-039 beq with Zero=1, then bne with Zero=1 -> PC_sel=1 on the first, PC_sel=0 on the second; each takes 3 cycles.
REQ-040 lw with 3 wait cycles in MRD -> MDR_LdEn only on the Ack cycle, then WB with RF_WrData_sel=1; 8 cycles total.
REQ-041 sb, Mem_Ack withheld, MEM_WAIT_MAX=15 -> ERR after 15 MWR cycles; Err=1 and Mem_Req=0 until Reset.
REQ-042 Opcode 010101 -> ERR directly from DEC.
REQ-043 Reset pulsed mid-MRD -> all outputs 0 immediately; IDLE, then IF one cycle after release.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// mc_defs: shared opcodes, ALU codes, state encoding and control-word type for the multicycle controller.
package mc_defs;

    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_LI   = 6'b111000;
    localparam logic [5:0] OP_LUI  = 6'b111001;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_LB   = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SB   = 6'b000111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_IF   = 4'd1;
    localparam logic [3:0] S_DEC  = 4'd2;
    localparam logic [3:0] S_EXR  = 4'd3;
    localparam logic [3:0] S_EXI  = 4'd4;
    localparam logic [3:0] S_BR   = 4'd5;
    localparam logic [3:0] S_ADR  = 4'd6;
    localparam logic [3:0] S_MRD  = 4'd7;
    localparam logic [3:0] S_MWR  = 4'd8;
    localparam logic [3:0] S_WB   = 4'd9;
    localparam logic [3:0] S_ERR  = 4'd10;

    typedef struct packed {
        logic       pc_sel;
        logic       pc_lden;
        logic       ir_lden;
        logic       mdr_lden;
        logic       rf_wren;
        logic       rf_b_sel;
        logic       rf_wrdata_sel;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic       mem_req;
        logic       mem_wren;
        logic       mem_instrsel;
        logic       byteop;
        logic       err;
    } ctrl_t;

    function automatic logic is_wait_state(input logic [3:0] s);
        return s == S_IF || s == S_MRD || s == S_MWR;
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op == OP_SB || op == OP_SW;
    endfunction

    function automatic logic [3:0] dec_next(input logic [5:0] op);
        return (op == OP_R) ? S_EXR :
               (op == OP_LI || op == OP_LUI || op == OP_ADDI || op == OP_ANDI || op == OP_ORI) ? S_EXI :
               (op == OP_B || op == OP_BEQ || op == OP_BNE) ? S_BR :
               (op == OP_LB || op == OP_LW || is_store(op)) ? S_ADR : S_ERR;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts memory wait cycles and flags the cycle whose increment would reach MAX.
module mc_wait_timer #(
    parameter int MAX = 15
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;

    assign expired = enable && cnt_q == W'(MAX - 1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (enable)
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle CPU control FSM with memory-wait timeout and sticky error state.
module mc_control_fsm
    import mc_defs::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       Mem_Ack,
    output logic       PC_sel,
    output logic       PC_LdEn,
    output logic       IR_LdEn,
    output logic       MDR_LdEn,
    output logic       RF_WrEn,
    output logic       RF_B_sel,
    output logic       RF_WrData_sel,
    output logic       ALU_Bin_sel,
    output logic [3:0] ALU_func,
    output logic       Mem_Req,
    output logic       Mem_WrEn,
    output logic       Mem_InstrSel,
    output logic       ByteOp,
    output logic       Err
);

    logic [3:0] state_q, state_d;
    logic       ld_q;
    logic       expired;
    logic       wait_en, wait_clr;
    logic       unused_func;
    ctrl_t      c;

    assign unused_func = ^Func[5:4];
    assign wait_en     = is_wait_state(state_q) && !Mem_Ack;
    assign wait_clr    = is_wait_state(state_d) && state_d != state_q;

    mc_wait_timer #(.MAX(MEM_WAIT_MAX)) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (wait_clr),
        .enable  (wait_en),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       state_d = S_IF;
            S_IF:         state_d = Mem_Ack ? S_DEC : expired ? S_ERR : S_IF;
            S_DEC:        state_d = dec_next(Opcode);
            S_EXR, S_EXI: state_d = S_WB;
            S_BR, S_WB:   state_d = S_IF;
            S_ADR:        state_d = is_store(Opcode) ? S_MWR : S_MRD;
            S_MRD:        state_d = Mem_Ack ? S_WB : expired ? S_ERR : S_MRD;
            S_MWR:        state_d = Mem_Ack ? S_IF : expired ? S_ERR : S_MWR;
            default:      state_d = S_ERR;
        endcase
    end

    // Only IR/MDR loads and the store-completion PC load look at Mem_Ack; all else is pure Moore.
    always_comb begin
        c = '0;
        case (state_q)
            S_IF: begin
                c.mem_req      = 1'b1;
                c.mem_instrsel = 1'b1;
                c.ir_lden      = Mem_Ack;
            end
            S_EXR: c.alu_func = Func[3:0];
            S_EXI: begin
                c.alu_bin_sel = 1'b1;
                c.alu_func    = (Opcode == OP_ANDI) ? ALU_AND : (Opcode == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_BR: begin
                c.rf_b_sel = 1'b1;
                c.alu_func = ALU_SUB;
                c.pc_lden  = 1'b1;
                c.pc_sel   = Opcode == OP_B || (Opcode == OP_BEQ && Zero) || (Opcode == OP_BNE && !Zero);
            end
            S_ADR: begin
                c.alu_bin_sel = 1'b1;
                c.alu_func    = ALU_ADD;
                c.rf_b_sel    = is_store(Opcode);
            end
            S_MRD: begin
                c.mem_req  = 1'b1;
                c.byteop   = Opcode == OP_LB;
                c.mdr_lden = Mem_Ack;
            end
            S_MWR: begin
                c.mem_req  = 1'b1;
                c.mem_wren = 1'b1;
                c.rf_b_sel = 1'b1;
                c.byteop   = Opcode == OP_SB;
                c.pc_lden  = Mem_Ack;
            end
            S_WB: begin
                c.rf_wren       = 1'b1;
                c.rf_wrdata_sel = ld_q;
                c.pc_lden       = 1'b1;
            end
            S_ERR: c.err = 1'b1;
            default: c = '0;
        endcase
    end

    assign PC_sel        = c.pc_sel;
    assign PC_LdEn       = c.pc_lden;
    assign IR_LdEn       = c.ir_lden;
    assign MDR_LdEn      = c.mdr_lden;
    assign RF_WrEn       = c.rf_wren;
    assign RF_B_sel      = c.rf_b_sel;
    assign RF_WrData_sel = c.rf_wrdata_sel;
    assign ALU_Bin_sel   = c.alu_bin_sel;
    assign ALU_func      = c.alu_func;
    assign Mem_Req       = c.mem_req;
    assign Mem_WrEn      = c.mem_wren;
    assign Mem_InstrSel  = c.mem_instrsel;
    assign ByteOp        = c.byteop;
    assign Err           = c.err;

    // MRD always exits straight to WB, so a one-cycle history bit identifies load write-back.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= state_q == S_MRD;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed vectors with a per-cycle expected control-word scoreboard.
module tb_mc_control_fsm;

    localparam logic [5:0] R    = 6'b100000;
    localparam logic [5:0] ADDI = 6'b110000;
    localparam logic [5:0] ORI  = 6'b110011;
    localparam logic [5:0] BEQ  = 6'b000000;
    localparam logic [5:0] BNE  = 6'b000001;
    localparam logic [5:0] LB   = 6'b000011;
    localparam logic [5:0] LW   = 6'b001111;
    localparam logic [5:0] SB   = 6'b000111;
    localparam logic [5:0] SW   = 6'b011111;
    localparam logic [5:0] BAD  = 6'b010101;

    localparam logic [16:0] ERRB = 17'h10000, PCS = 17'h08000, PCL = 17'h04000, IRL = 17'h02000;
    localparam logic [16:0] MDRL = 17'h01000, RFW = 17'h00800, RFB = 17'h00400, WDS = 17'h00200;
    localparam logic [16:0] ABS  = 17'h00100, MRQ = 17'h00008, MWE = 17'h00004, MIS = 17'h00002;
    localparam logic [16:0] BYT  = 17'h00001, IFA = MRQ | MIS | IRL, IFW = MRQ | MIS;

    logic       Clk = 1'b0, Reset = 1'b1, Zero = 1'b0, Mem_Ack = 1'b0;
    logic [5:0] Opcode = 6'd0, Func = 6'b110011;
    logic       PC_sel, PC_LdEn, IR_LdEn, MDR_LdEn, RF_WrEn, RF_B_sel, RF_WrData_sel, ALU_Bin_sel;
    logic [3:0] ALU_func;
    logic       Mem_Req, Mem_WrEn, Mem_InstrSel, ByteOp, Err;
    logic [16:0] act;

    typedef struct {
        string       n;
        logic [16:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0;
    event chk_ev;

    mc_control_fsm #(.MEM_WAIT_MAX(15)) dut (
        .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Func(Func), .Zero(Zero), .Mem_Ack(Mem_Ack),
        .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .MDR_LdEn(MDR_LdEn),
        .RF_WrEn(RF_WrEn), .RF_B_sel(RF_B_sel), .RF_WrData_sel(RF_WrData_sel),
        .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .Mem_Req(Mem_Req), .Mem_WrEn(Mem_WrEn),
        .Mem_InstrSel(Mem_InstrSel), .ByteOp(ByteOp), .Err(Err)
    );

    assign act = {Err, PC_sel, PC_LdEn, IR_LdEn, MDR_LdEn, RF_WrEn, RF_B_sel, RF_WrData_sel,
                  ALU_Bin_sel, ALU_func, Mem_Req, Mem_WrEn, Mem_InstrSel, ByteOp};

    always #5 Clk = ~Clk;

    function automatic logic [16:0] af(input logic [3:0] f);
        return {9'b0, f, 4'b0};
    endfunction

    task automatic push(input string n, input logic [16:0] e);
        exp_t t;
        t.n = n;
        t.v = e;
        exp_q.push_back(t);
    endtask

    task automatic step(input string n, input logic [5:0] op, input logic z, input logic ack, input logic [16:0] e);
        Opcode  = op;
        Zero    = z;
        Mem_Ack = ack;
        push(n, e);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        exp_t t;
        forever begin
            @(negedge Clk or chk_ev);
            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                total++;
                if (act !== t.v) begin
                    bad++;
                    $display("FAIL %s: got %05h expected %05h", t.n, act, t.v);
                end
            end
        end
    end

    initial begin
        @(posedge Clk);
        #1;
        step("rst0", ADDI, 0, 1, 0);
        step("rst1", ADDI, 0, 1, 0);
        Reset = 1'b0;
        step("idle", ADDI, 0, 1, 0);
        step("addi_if", ADDI, 0, 1, IFA);
        step("addi_dec", ADDI, 0, 1, 0);
        step("addi_exi", ADDI, 0, 1, ABS | af(4'b0000));
        step("addi_wb", ADDI, 0, 1, RFW | PCL);
        step("beq_if", BEQ, 1, 1, IFA);
        step("beq_dec", BEQ, 1, 1, 0);
        step("beq_br", BEQ, 1, 1, RFB | af(4'b0001) | PCL | PCS);
        step("bne_if", BNE, 1, 1, IFA);
        step("bne_dec", BNE, 1, 1, 0);
        step("bne_br", BNE, 1, 1, RFB | af(4'b0001) | PCL);
        step("r_if", R, 0, 1, IFA);
        step("r_dec", R, 0, 1, 0);
        step("r_exr", R, 0, 1, af(4'b0011));
        step("r_wb", R, 0, 1, RFW | PCL);
        step("ori_if", ORI, 0, 1, IFA);
        step("ori_dec", ORI, 0, 1, 0);
        step("ori_exi", ORI, 0, 1, ABS | af(4'b0011));
        step("ori_wb", ORI, 0, 1, RFW | PCL);
        step("lw_if", LW, 0, 1, IFA);
        step("lw_dec", LW, 0, 1, 0);
        step("lw_adr", LW, 0, 1, ABS);
        for (int i = 0; i < 3; i++) step("lw_mrd_wait", LW, 0, 0, MRQ);
        step("lw_mrd_ack", LW, 0, 1, MRQ | MDRL);
        step("lw_wb", LW, 0, 1, RFW | WDS | PCL);
        step("lb_if", LB, 0, 1, IFA);
        step("lb_dec", LB, 0, 1, 0);
        step("lb_adr", LB, 0, 1, ABS);
        step("lb_mrd", LB, 0, 1, MRQ | BYT | MDRL);
        step("lb_wb", LB, 0, 1, RFW | WDS | PCL);
        step("sw_if", SW, 0, 1, IFA);
        step("sw_dec", SW, 0, 1, 0);
        step("sw_adr", SW, 0, 1, ABS | RFB);
        step("sw_mwr", SW, 0, 1, MRQ | MWE | RFB | PCL);
        for (int i = 0; i < 14; i++) step("if_wait", ADDI, 0, 0, IFW);
        step("if_ack_at_limit", ADDI, 0, 1, IFA);
        step("lim_dec", ADDI, 0, 1, 0);
        step("lim_exi", ADDI, 0, 1, ABS);
        step("lim_wb", ADDI, 0, 1, RFW | PCL);
        step("sb_if", SB, 0, 1, IFA);
        step("sb_dec", SB, 0, 1, 0);
        step("sb_adr", SB, 0, 1, ABS | RFB);
        for (int i = 0; i < 15; i++) step("sb_mwr_wait", SB, 0, 0, MRQ | MWE | RFB | BYT);
        step("sb_err0", SB, 0, 0, ERRB);
        step("sb_err_ack", SB, 0, 1, ERRB);
        step("sb_err2", ADDI, 0, 1, ERRB);
        Reset = 1'b1;
        step("rst_err", ADDI, 0, 1, 0);
        Reset = 1'b0;
        step("idle2", ADDI, 0, 1, 0);
        step("bad_if", BAD, 0, 1, IFA);
        step("bad_dec", BAD, 0, 1, 0);
        step("bad_err", BAD, 0, 1, ERRB);
        step("bad_err2", ADDI, 0, 1, ERRB);
        Reset = 1'b1;
        step("rst_bad", ADDI, 0, 1, 0);
        Reset = 1'b0;
        step("idle3", LW, 0, 1, 0);
        step("lw2_if", LW, 0, 1, IFA);
        step("lw2_dec", LW, 0, 1, 0);
        step("lw2_adr", LW, 0, 1, ABS);
        Mem_Ack = 1'b0;
        push("lw2_mrd", MRQ);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1 push("rst_async", 0);
        ->chk_ev;
        @(posedge Clk);
        #1;
        step("rst_hold", LW, 0, 0, 0);
        Reset = 1'b0;
        step("idle4", LW, 0, 0, 0);
        step("if_after_rst", LW, 0, 0, IFW);
        @(negedge Clk);
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
